// File: rtl/adpll_lock_controller_pkg.sv
// Shared definitions for the ADPLL lock controller and its helper blocks:
// state encoding plus default thresholds and loop-filter shift amounts.
package adpll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } adpll_state_e;

  localparam int DEF_WIDTH         = 20;
  localparam int DEF_SHIFT_W       = 4;
  localparam int DEF_COARSE_SHIFT  = 2;
  localparam int DEF_FINE_SHIFT    = 6;
  localparam int DEF_COARSE_THRESH = 32;
  localparam int DEF_LOCK_THRESH   = 4;
  localparam int DEF_UNLOCK_THRESH = 64;
  localparam int DEF_LOCK_COUNT    = 16;
  localparam int DEF_UNLOCK_COUNT  = 4;
  localparam int DEF_TIMEOUT       = 4096;

endpackage

// File: rtl/adpll_lock_controller_phase_err_abs.sv
// Saturating magnitude of a signed phase-error sample. The most negative
// input has no positive twin, so it is clamped to the largest magnitude
// instead of wrapping back to zero and looking like a perfect sample.
module phase_err_abs #(
  parameter int WIDTH = adpll_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] err_i,
  output logic [WIDTH-2:0] mag_o
);

  logic [WIDTH-1:0] negErr;

  // Two's-complement negation, then pick the magnitude with saturation
  always_comb begin
    negErr = '0 - err_i;
    if (err_i[WIDTH-1]) begin
      if (err_i[WIDTH-2:0] == '0) begin
        mag_o = '1;
      end else begin
        mag_o = negErr[WIDTH-2:0];
      end
    end else begin
      mag_o = err_i[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/adpll_lock_controller.sv
// ADPLL acquisition sequencer: clears the loop filter, runs a high-gain
// coarse pull-in, a low-gain fine settle, then watches for loss of lock.
// A sample counter bounds the time spent acquiring before giving up.
module adpll_lock_controller
  import adpll_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SHIFT_W       = DEF_SHIFT_W,
  parameter int COARSE_SHIFT  = DEF_COARSE_SHIFT,
  parameter int FINE_SHIFT    = DEF_FINE_SHIFT,
  parameter int COARSE_THRESH = DEF_COARSE_THRESH,
  parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic               fpga_clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               pd_valid_i,
  input  logic [WIDTH-1:0]   pd_clock_cycles_i,
  output logic [SHIFT_W-1:0] gain_shift_o,
  output logic               loop_enable_o,
  output logic               filter_clear_o,
  output logic               locked_o,
  output logic               timeout_o,
  output logic [2:0]         state_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-2:0]   COARSE_T = (WIDTH-1)'(COARSE_THRESH);
  localparam logic [WIDTH-2:0]   LOCK_T   = (WIDTH-1)'(LOCK_THRESH);
  localparam logic [WIDTH-2:0]   UNLOCK_T = (WIDTH-1)'(UNLOCK_THRESH);
  localparam logic [SHIFT_W-1:0] COARSE_G = SHIFT_W'(COARSE_SHIFT);
  localparam logic [SHIFT_W-1:0] FINE_G   = SHIFT_W'(FINE_SHIFT);

  adpll_state_e state_q, state_d;
  logic [GW-1:0] goodCnt_q, goodCnt_d, goodInc;
  logic [BW-1:0] badCnt_q, badCnt_d, badInc;
  logic [SW-1:0] sampCnt_q, sampCnt_d, sampInc;

  logic [SHIFT_W-1:0] gain_q, gain_d;
  logic loopEn_q, loopEn_d, clear_q, clear_d, locked_q, locked_d, timeout_q, timeout_d;

  logic [WIDTH-2:0] errMag;
  logic coarseGood, fineGood, sampleBad, timedOut;

  phase_err_abs #(.WIDTH(WIDTH)) u_abs (
    .err_i (pd_clock_cycles_i),
    .mag_o (errMag)
  );

  // Sample classification and saturating counter increments
  always_comb begin
    coarseGood = (errMag <= COARSE_T);
    fineGood   = (errMag <= LOCK_T);
    sampleBad  = (errMag > UNLOCK_T);
    goodInc    = (goodCnt_q == {GW{1'b1}}) ? goodCnt_q : goodCnt_q + GW'(1);
    badInc     = (badCnt_q == {BW{1'b1}}) ? badCnt_q : badCnt_q + BW'(1);
    sampInc    = (sampCnt_q == {SW{1'b1}}) ? sampCnt_q : sampCnt_q + SW'(1);
    timedOut   = (sampInc >= SW'(TIMEOUT));
  end

  // Next-state, counter updates and registered-output decode
  always_comb begin
    state_d   = state_q;
    goodCnt_d = goodCnt_q;
    badCnt_d  = badCnt_q;
    sampCnt_d = sampCnt_q;
    if (!enable_i) begin
      state_d   = ST_IDLE;
      goodCnt_d = '0;
      badCnt_d  = '0;
      sampCnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CLEAR;
        ST_CLEAR: begin
          goodCnt_d = '0;
          badCnt_d  = '0;
          sampCnt_d = '0;
          state_d   = ST_COARSE;
        end
        ST_COARSE: begin
          if (pd_valid_i) begin
            sampCnt_d = sampInc;
            if (timedOut) begin
              state_d = ST_FAIL;
            end else if (coarseGood) begin
              if (goodInc >= GW'(LOCK_COUNT)) begin
                state_d   = ST_FINE;
                goodCnt_d = '0;
              end else begin
                goodCnt_d = goodInc;
              end
            end else begin
              goodCnt_d = '0;
            end
          end
        end
        ST_FINE: begin
          if (pd_valid_i) begin
            sampCnt_d = sampInc;
            if (timedOut) begin
              state_d = ST_FAIL;
            end else if (sampleBad) begin
              state_d   = ST_COARSE;
              goodCnt_d = '0;
            end else if (fineGood) begin
              if (goodInc >= GW'(LOCK_COUNT)) begin
                state_d   = ST_LOCKED;
                goodCnt_d = '0;
                badCnt_d  = '0;
                sampCnt_d = '0;
              end else begin
                goodCnt_d = goodInc;
              end
            end else begin
              goodCnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (pd_valid_i) begin
            if (sampleBad) begin
              if (badInc >= BW'(UNLOCK_COUNT)) begin
                state_d   = ST_COARSE;
                goodCnt_d = '0;
                badCnt_d  = '0;
                sampCnt_d = '0;
              end else begin
                badCnt_d = badInc;
              end
            end else begin
              badCnt_d = '0;
            end
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end

    gain_d    = (state_d == ST_FINE || state_d == ST_LOCKED) ? FINE_G : COARSE_G;
    loopEn_d  = (state_d == ST_COARSE || state_d == ST_FINE || state_d == ST_LOCKED);
    clear_d   = (state_d == ST_CLEAR);
    locked_d  = (state_d == ST_LOCKED);
    timeout_d = (state_d == ST_FAIL);
  end

  // State, counters and outputs all update together on the clock edge
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      goodCnt_q <= '0;
      badCnt_q  <= '0;
      sampCnt_q <= '0;
      gain_q    <= COARSE_G;
      loopEn_q  <= 1'b0;
      clear_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      goodCnt_q <= goodCnt_d;
      badCnt_q  <= badCnt_d;
      sampCnt_q <= sampCnt_d;
      gain_q    <= gain_d;
      loopEn_q  <= loopEn_d;
      clear_q   <= clear_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign gain_shift_o   = gain_q;
  assign loop_enable_o  = loopEn_q;
  assign filter_clear_o = clear_q;
  assign locked_o       = locked_q;
  assign timeout_o      = timeout_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_adpll_lock_controller.sv
// Self-checking bench for the ADPLL lock controller with short counts so
// every path (lock, unlock, timeout, enable drop, async reset) is reached.
module tb_adpll_lock_controller;
  import adpll_pkg::*;

  logic        fpga_clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        pd_valid_i;
  logic [19:0] pd_clock_cycles_i;
  logic [3:0]  gain_shift_o;
  logic        loop_enable_o;
  logic        filter_clear_o;
  logic        locked_o;
  logic        timeout_o;
  logic [2:0]  state_o;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
  } exp_t;

  exp_t expQ[$];

  adpll_lock_controller #(
    .WIDTH(20), .SHIFT_W(4), .COARSE_SHIFT(2), .FINE_SHIFT(6),
    .COARSE_THRESH(32), .LOCK_THRESH(4), .UNLOCK_THRESH(64),
    .LOCK_COUNT(4), .UNLOCK_COUNT(2), .TIMEOUT(20)
  ) dut (
    .fpga_clk_i        (fpga_clk_i),
    .reset_i           (reset_i),
    .enable_i          (enable_i),
    .pd_valid_i        (pd_valid_i),
    .pd_clock_cycles_i (pd_clock_cycles_i),
    .gain_shift_o      (gain_shift_o),
    .loop_enable_o     (loop_enable_o),
    .filter_clear_o    (filter_clear_o),
    .locked_o          (locked_o),
    .timeout_o         (timeout_o),
    .state_o           (state_o)
  );

  // Free-running system clock
  always #5 fpga_clk_i = ~fpga_clk_i;

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Check every output the expected state pins down
  task automatic compareOutputs(input string tag, input logic [2:0] st);
    logic running;
    running = (st == ST_COARSE || st == ST_FINE || st == ST_LOCKED);
    checkOutput({tag, ".state"}, 32'(state_o), 32'(st));
    if (running)
      checkOutput({tag, ".gain"}, 32'(gain_shift_o), (st == ST_COARSE) ? 32'd2 : 32'd6);
    if (st != ST_CLEAR)
      checkOutput({tag, ".loopEn"}, 32'(loop_enable_o), 32'(running));
    checkOutput({tag, ".clear"}, 32'(filter_clear_o), 32'(st == ST_CLEAR));
    checkOutput({tag, ".locked"}, 32'(locked_o), 32'(st == ST_LOCKED));
    checkOutput({tag, ".timeout"}, 32'(timeout_o), 32'(st == ST_FAIL));
  endtask

  // Drive one cycle of inputs, queue the expected state, then score it
  task automatic applyStimulus(input string tag, input logic en, input logic v,
                               input int err, input logic [2:0] expSt);
    exp_t e;
    enable_i          = en;
    pd_valid_i        = v;
    pd_clock_cycles_i = err[19:0];
    expQ.push_back('{tag: tag, st: expSt});
    @(posedge fpga_clk_i);
    #1;
    pd_valid_i = 1'b0;
    e = expQ.pop_front();
    compareOutputs(e.tag, e.st);
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, elapsed %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed acquisition scenarios
  initial begin
    reset_i           = 1'b0;
    enable_i          = 1'b0;
    pd_valid_i        = 1'b0;
    pd_clock_cycles_i = '0;
    #12;
    compareOutputs("reset", ST_IDLE);
    checkOutput("reset.gain", 32'(gain_shift_o), 32'd2);
    reset_i = 1'b1;

    applyStimulus("enable", 1, 0, 0, ST_CLEAR);
    applyStimulus("clearSampleIgnored", 1, 1, 10, ST_COARSE);
    repeat (3) applyStimulus("coarseGood", 1, 1, 10, ST_COARSE);
    applyStimulus("coarseToFine", 1, 1, 10, ST_FINE);

    applyStimulus("fine3", 1, 1, 3, ST_FINE);
    applyStimulus("fineNeg4", 1, 1, -4, ST_FINE);
    applyStimulus("fine2", 1, 1, 2, ST_FINE);
    applyStimulus("fineToLocked", 1, 1, 0, ST_LOCKED);

    applyStimulus("lockedBad1", 1, 1, 100, ST_LOCKED);
    applyStimulus("lockedGood", 1, 1, 0, ST_LOCKED);
    applyStimulus("locked64a", 1, 1, 64, ST_LOCKED);
    applyStimulus("locked64b", 1, 1, 64, ST_LOCKED);
    applyStimulus("lockedBadA", 1, 1, -100, ST_LOCKED);
    applyStimulus("unlock", 1, 1, -100, ST_COARSE);

    applyStimulus("coarse32a", 1, 1, 32, ST_COARSE);
    applyStimulus("coarse32b", 1, 1, 32, ST_COARSE);
    applyStimulus("coarse33", 1, 1, 33, ST_COARSE);
    repeat (3) applyStimulus("coarse32c", 1, 1, 32, ST_COARSE);
    applyStimulus("coarse32ToFine", 1, 1, 32, ST_FINE);

    repeat (3) applyStimulus("fineRun3", 1, 1, 3, ST_FINE);
    applyStimulus("fine5Resets", 1, 1, 5, ST_FINE);
    repeat (3) applyStimulus("fineZero", 1, 1, 0, ST_FINE);
    applyStimulus("fineZeroLock", 1, 1, 0, ST_LOCKED);
    applyStimulus("lockedBadB", 1, 1, 100, ST_LOCKED);
    applyStimulus("unlockB", 1, 1, 100, ST_COARSE);

    repeat (3) applyStimulus("reacq", 1, 1, 10, ST_COARSE);
    applyStimulus("reacqFine", 1, 1, 10, ST_FINE);
    repeat (2) applyStimulus("fineRun", 1, 1, 3, ST_FINE);
    applyStimulus("fine70", 1, 1, 70, ST_COARSE);
    repeat (3) applyStimulus("afterFine70", 1, 1, 10, ST_COARSE);
    applyStimulus("enableDropOn4th", 0, 1, 10, ST_IDLE);
    applyStimulus("idleHold", 0, 0, 0, ST_IDLE);

    applyStimulus("reenable", 1, 0, 0, ST_CLEAR);
    applyStimulus("toStart", 1, 0, 0, ST_COARSE);
    repeat (3) applyStimulus("toGood", 1, 1, 10, ST_COARSE);
    applyStimulus("mostNeg", 1, 1, -524288, ST_COARSE);
    repeat (12) applyStimulus("to500", 1, 1, 500, ST_COARSE);
    repeat (3) applyStimulus("toGoodLate", 1, 1, 10, ST_COARSE);
    applyStimulus("timeoutBeatsAdvance", 1, 1, 10, ST_FAIL);
    applyStimulus("failHold", 1, 1, 0, ST_FAIL);
    applyStimulus("failExit", 0, 0, 0, ST_IDLE);
    applyStimulus("failReenable", 1, 0, 0, ST_CLEAR);
    applyStimulus("failRestart", 1, 0, 0, ST_COARSE);

    repeat (3) applyStimulus("preLock", 1, 1, 10, ST_COARSE);
    applyStimulus("preLockFine", 1, 1, 10, ST_FINE);
    repeat (3) applyStimulus("preLockZero", 1, 1, 0, ST_FINE);
    applyStimulus("preLockLocked", 1, 1, 0, ST_LOCKED);

    #2;
    reset_i = 1'b0;
    #1;
    compareOutputs("asyncReset", ST_IDLE);
    checkOutput("asyncReset.gain", 32'(gain_shift_o), 32'd2);
    @(posedge fpga_clk_i);
    #1;
    compareOutputs("resetHeld", ST_IDLE);
    reset_i = 1'b1;

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
